// File: rtl/multi_pwm_gen.sv
// Multi-channel PWM generator: shared free-running counter, double-buffered period/duty.
// Define PWM_CENTER_ALIGN_EN for up/down (center-aligned) counting.
module multi_pwm_gen #(
   parameter int WIDTH    = 8,
   parameter int CHANNELS = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      en,
   input  logic [WIDTH-1:0]          period,
   input  logic [CHANNELS*WIDTH-1:0] duty,
   input  logic                      load,
   output logic [WIDTH-1:0]          counter,
   output logic [CHANNELS-1:0]       pwmout,
   output logic                      period_start
);

   logic [WIDTH-1:0]          counter_r;
   logic [CHANNELS-1:0]       pwmout_r;
   logic                      period_start_r;
   logic                      en_r;
   logic [WIDTH-1:0]          period_act_r;
   logic [CHANNELS*WIDTH-1:0] duty_act_r;
   logic [WIDTH-1:0]          period_pend_r;
   logic [CHANNELS*WIDTH-1:0] duty_pend_r;
   logic                      pend_r;

   logic [WIDTH-1:0]          counter_nxt_s;
   logic [CHANNELS-1:0]       pwmout_nxt_s;
   logic                      start_nxt_s;
   logic                      boundary_s;
   logic [WIDTH-1:0]          period_act_nxt_s;
   logic [CHANNELS*WIDTH-1:0] duty_act_nxt_s;
   logic [WIDTH-1:0]          period_pend_nxt_s;
   logic [CHANNELS*WIDTH-1:0] duty_pend_nxt_s;
   logic                      pend_nxt_s;
`ifdef PWM_CENTER_ALIGN_EN
   logic                      dir_r;      // 1'b0 = counting up, 1'b1 = counting down
   logic                      dir_nxt_s;
`endif

   // Counter sequencing and boundary detection
   always_comb begin
      counter_nxt_s = counter_r;
      start_nxt_s   = 1'b0;
      boundary_s    = 1'b0;
`ifdef PWM_CENTER_ALIGN_EN
      dir_nxt_s     = dir_r;
`endif
      if (!en) begin
         counter_nxt_s = '0;
         boundary_s    = 1'b1;
`ifdef PWM_CENTER_ALIGN_EN
         dir_nxt_s     = 1'b0;
`endif
      end else if (!en_r) begin
         // first enabled edge parks at 0 and opens a fresh period
         counter_nxt_s = '0;
         boundary_s    = 1'b1;
         start_nxt_s   = 1'b1;
`ifdef PWM_CENTER_ALIGN_EN
         dir_nxt_s     = 1'b0;
`endif
      end else begin
`ifdef PWM_CENTER_ALIGN_EN
         if (!dir_r && (counter_r < period_act_r)) begin
            counter_nxt_s = counter_r + WIDTH'(1);
         end else if ((period_act_r == '0) || (counter_r <= WIDTH'(1))) begin
            counter_nxt_s = '0;
            boundary_s    = 1'b1;
            start_nxt_s   = 1'b1;
            dir_nxt_s     = 1'b0;
         end else begin
            counter_nxt_s = counter_r - WIDTH'(1);
            dir_nxt_s     = 1'b1;
         end
`else
         if (counter_r >= period_act_r) begin
            counter_nxt_s = '0;
            boundary_s    = 1'b1;
            start_nxt_s   = 1'b1;
         end else begin
            counter_nxt_s = counter_r + WIDTH'(1);
         end
`endif
      end
   end

   // Double-buffer update and next-state PWM compare
   always_comb begin
      period_act_nxt_s  = period_act_r;
      duty_act_nxt_s    = duty_act_r;
      period_pend_nxt_s = period_pend_r;
      duty_pend_nxt_s   = duty_pend_r;
      pend_nxt_s        = pend_r;
      pwmout_nxt_s      = '0;
      if (boundary_s) begin
         if (load) begin
            period_act_nxt_s = period;
            duty_act_nxt_s   = duty;
         end else if (pend_r) begin
            period_act_nxt_s = period_pend_r;
            duty_act_nxt_s   = duty_pend_r;
         end else begin
            period_act_nxt_s = period_act_r;
         end
         pend_nxt_s = 1'b0;
      end else if (load) begin
         period_pend_nxt_s = period;
         duty_pend_nxt_s   = duty;
         pend_nxt_s        = 1'b1;
      end else begin
         pend_nxt_s = pend_r;
      end
      // compare against next-state values so counter and pwmout stay coherent
      for (int i = 0; i < CHANNELS; i++) begin
         pwmout_nxt_s[i] = en & (counter_nxt_s < duty_act_nxt_s[i*WIDTH +: WIDTH]);
      end
   end

   // State registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         counter_r      <= '0;
         pwmout_r       <= '0;
         period_start_r <= 1'b0;
         en_r           <= 1'b0;
         period_act_r   <= {WIDTH{1'b1}};
         duty_act_r     <= '0;
         period_pend_r  <= '0;
         duty_pend_r    <= '0;
         pend_r         <= 1'b0;
`ifdef PWM_CENTER_ALIGN_EN
         dir_r          <= 1'b0;
`endif
      end else begin
         counter_r      <= counter_nxt_s;
         pwmout_r       <= pwmout_nxt_s;
         period_start_r <= start_nxt_s;
         en_r           <= en;
         period_act_r   <= period_act_nxt_s;
         duty_act_r     <= duty_act_nxt_s;
         period_pend_r  <= period_pend_nxt_s;
         duty_pend_r    <= duty_pend_nxt_s;
         pend_r         <= pend_nxt_s;
`ifdef PWM_CENTER_ALIGN_EN
         dir_r          <= dir_nxt_s;
`endif
      end
   end

   assign counter      = counter_r;
   assign pwmout       = pwmout_r;
   assign period_start = period_start_r;

endmodule
